// File: rtl/grid_stream_reader.sv
// grid_stream_reader: scans the 28x28 one-bit drawing grid in row-major order
// and streams each cell as a scaled activation on a valid/ready interface.
// It also counts set cells and, when GRID_BBOX_EN is defined, tracks their
// bounding box. Without GRID_BBOX_EN the bbox ports are tied to reset values.
module grid_stream_reader #(
    parameter int unsigned           GRID_SIZE = 28,
    parameter int unsigned           PIX_W     = 8,
    parameter logic [PIX_W-1:0]      ON_VALUE  = 8'd255
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             mem_rd,
    output logic [9:0]       mem_addr,
    input  logic             mem_data,
    output logic [PIX_W-1:0] px_data,
    output logic [9:0]       px_index,
    output logic             px_valid,
    input  logic             px_ready,
    output logic             px_last,
    output logic [9:0]       set_count,
    output logic [4:0]       bbox_min_x,
    output logic [4:0]       bbox_max_x,
    output logic [4:0]       bbox_min_y,
    output logic [4:0]       bbox_max_y,
    output logic             bbox_valid
);

    localparam logic [9:0] CELLS    = 10'(GRID_SIZE * GRID_SIZE);
    localparam logic [9:0] LAST_IDX = 10'(GRID_SIZE * GRID_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FINISH
    } state_t;

    state_t state;
    state_t state_next;

    // read side
    logic [9:0] rd_ptr;
    logic       rd_pending;
    logic [9:0] pend_index;
    logic       issue;
    logic       launch;
    logic [2:0] pending_after;

    // two-entry output FIFO, entry 0 is the head
    logic [1:0] fifo_count;
    logic       bit0;
    logic       bit1;
    logic [9:0] idx0;
    logic [9:0] idx1;
    logic       push;
    logic       pop;

    assign launch   = (state == IDLE) && start;
    assign push     = rd_pending;
    assign px_valid = (fifo_count != 2'd0);
    assign pop      = px_valid && px_ready;

    // A beat leaving this cycle frees its slot, so it is credited before the
    // limit of 2 is applied; this keeps one read per cycle when px_ready is high.
    assign pending_after = {1'b0, fifo_count} + {2'b00, rd_pending} - {2'b00, pop};
    assign issue         = (state == SCAN) && (rd_ptr < CELLS) && (pending_after < 3'd2);

    assign mem_rd   = issue;
    assign mem_addr = rd_ptr;

    assign px_data  = bit0 ? ON_VALUE : '0;
    assign px_index = idx0;
    assign px_last  = px_valid && (idx0 == LAST_IDX);

    assign busy = (state == SCAN);
    assign done = (state == FINISH);

    // state register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (pop && (idx0 == LAST_IDX)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // read pointer and one-deep in-flight tracker
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rd_ptr     <= '0;
            rd_pending <= 1'b0;
            pend_index <= '0;
        end else begin
            rd_pending <= issue;
            if (launch) begin
                rd_ptr <= '0;
            end else if (issue) begin
                rd_ptr     <= rd_ptr + 10'd1;
                pend_index <= rd_ptr;
            end
        end
    end

    // output FIFO: capture read data with its index, shift on accepted beats
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            fifo_count <= '0;
            bit0       <= 1'b0;
            bit1       <= 1'b0;
            idx0       <= '0;
            idx1       <= '0;
        end else if (launch) begin
            fifo_count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fifo_count == 2'd0) begin
                        bit0 <= mem_data;
                        idx0 <= pend_index;
                    end else begin
                        bit1 <= mem_data;
                        idx1 <= pend_index;
                    end
                    fifo_count <= fifo_count + 2'd1;
                end
                2'b01: begin
                    bit0       <= bit1;
                    idx0       <= idx1;
                    fifo_count <= fifo_count - 2'd1;
                end
                2'b11: begin
                    if (fifo_count == 2'd1) begin
                        bit0 <= mem_data;
                        idx0 <= pend_index;
                    end else begin
                        bit0 <= bit1;
                        idx0 <= idx1;
                        bit1 <= mem_data;
                        idx1 <= pend_index;
                    end
                end
                default: ;
            endcase
        end
    end

    // set-cell counter, saturating at the cell count
    always_ff @(posedge CLOCK_50) begin
        if (reset || launch) begin
            set_count <= '0;
        end else if (push && mem_data && (set_count != CELLS)) begin
            set_count <= set_count + 10'd1;
        end
    end

`ifdef GRID_BBOX_EN
    localparam logic [4:0] COL_LAST = 5'(GRID_SIZE - 1);

    logic [4:0] cap_x;
    logic [4:0] cap_y;
    logic [4:0] min_x;
    logic [4:0] max_x;
    logic [4:0] min_y;
    logic [4:0] max_y;
    logic       box_seen;

    // column/row of the captured cell tracked incrementally, bbox widened on set cells
    always_ff @(posedge CLOCK_50) begin
        if (reset || launch) begin
            cap_x    <= '0;
            cap_y    <= '0;
            min_x    <= '1;
            max_x    <= '0;
            min_y    <= '1;
            max_y    <= '0;
            box_seen <= 1'b0;
        end else if (push) begin
            if (cap_x == COL_LAST) begin
                cap_x <= '0;
                cap_y <= cap_y + 5'd1;
            end else begin
                cap_x <= cap_x + 5'd1;
            end
            if (mem_data) begin
                box_seen <= 1'b1;
                if (cap_x < min_x) min_x <= cap_x;
                if (cap_x > max_x) max_x <= cap_x;
                if (cap_y < min_y) min_y <= cap_y;
                if (cap_y > max_y) max_y <= cap_y;
            end
        end
    end

    assign bbox_min_x = min_x;
    assign bbox_max_x = max_x;
    assign bbox_min_y = min_y;
    assign bbox_max_y = max_y;
    assign bbox_valid = box_seen;
`else
    assign bbox_min_x = '1;
    assign bbox_max_x = '0;
    assign bbox_min_y = '1;
    assign bbox_max_y = '0;
    assign bbox_valid = 1'b0;
`endif

endmodule

// File: tb/tb_grid_stream_reader.sv
// Directed bench for grid_stream_reader; bbox expectations follow GRID_BBOX_EN.
module tb_grid_stream_reader;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       start    = 1'b0;
    logic       mem_data = 1'b0;
    logic       px_ready = 1'b0;
    logic       busy, done, mem_rd, px_valid, px_last, bbox_valid;
    logic [9:0] mem_addr, px_index, set_count;
    logic [7:0] px_data;
    logic [4:0] bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y;

    grid_stream_reader #(.GRID_SIZE(28), .PIX_W(8), .ON_VALUE(8'd255)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .busy(busy), .done(done),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .px_data(px_data), .px_index(px_index), .px_valid(px_valid), .px_ready(px_ready),
        .px_last(px_last), .set_count(set_count),
        .bbox_min_x(bbox_min_x), .bbox_max_x(bbox_max_x),
        .bbox_min_y(bbox_min_y), .bbox_max_y(bbox_max_y), .bbox_valid(bbox_valid)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // grid memory with one-cycle read latency
    logic grid [0:783];
    always @(posedge CLOCK_50) if (mem_rd) mem_data <= grid[mem_addr];

    int tests = 0;
    int fails = 0;

    // results of the most recent scan
    int beats, beat_err, stall_err, last_cnt, done_cnt, done_edge, max_pend;
    int first_valid, ones_cnt, one_idx, exp_idx, reset_hit;
    logic first_busy, first_rd;
    logic [9:0] first_addr;

    // expected values derived from the grid contents
    int exp_cnt, exp_minx, exp_maxx, exp_miny, exp_maxy, exp_bv;

    logic [63:0] out_vec;
    logic [63:0] rst_vec;
    assign out_vec = {busy, done, mem_rd, mem_addr, px_data, px_index, px_valid, px_last,
                      set_count, bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y, bbox_valid};
    assign rst_vec = {3'b000, 10'd0, 8'd0, 10'd0, 2'b00, 10'd0,
                      5'd31, 5'd0, 5'd31, 5'd0, 1'b0};

    function automatic void compute_expect();
        exp_cnt = 0; exp_minx = 31; exp_maxx = 0; exp_miny = 31; exp_maxy = 0; exp_bv = 0;
        for (int i = 0; i < 784; i++) begin
            if (grid[i]) begin
                exp_cnt++;
`ifdef GRID_BBOX_EN
                exp_bv = 1;
                if (i % 28 < exp_minx) exp_minx = i % 28;
                if (i % 28 > exp_maxx) exp_maxx = i % 28;
                if (i / 28 < exp_miny) exp_miny = i / 28;
                if (i / 28 > exp_maxy) exp_maxy = i / 28;
`endif
            end
        end
    endfunction

    // mode 0: px_ready held high; mode 1: px_ready 1,0,0,1 repeating
    task automatic run_scan(input int mode, input int rst_idx, input int restart_idx);
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data  = '0;
        logic [9:0] prev_idx   = '0;
        logic       prev_last  = 1'b0;
        int issued = 0;
        int accepted = 0;
        int restarted = 0;
        beats = 0; beat_err = 0; stall_err = 0; last_cnt = 0; done_cnt = 0;
        done_edge = -1; max_pend = 0; first_valid = -1; ones_cnt = 0; one_idx = -1;
        exp_idx = 0; reset_hit = 0;
        @(posedge CLOCK_50); #1 start = 1'b1;
        @(posedge CLOCK_50); #1 start = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            start    = 1'b0;
            px_ready = (mode == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3));
            #1;
            if (n == 0) begin first_busy = busy; first_rd = mem_rd; first_addr = mem_addr; end
            if (px_valid && first_valid < 0) first_valid = n;
            if (prev_stall) begin
                if (!px_valid || px_data !== prev_data || px_index !== prev_idx || px_last !== prev_last)
                    stall_err++;
            end
            if (mem_rd) issued++;
            if (px_valid && px_ready) begin
                if (px_index !== 10'(exp_idx) || px_data !== (grid[exp_idx] ? 8'd255 : 8'd0)
                    || px_last !== (exp_idx == 783)) beat_err++;
                if (px_data == 8'd255) begin ones_cnt++; one_idx = int'(px_index); end
                if (px_last) last_cnt++;
                exp_idx++; beats++; accepted++;
            end else if (px_last) begin
                last_cnt = last_cnt + 0;
            end
            if (issued - accepted > max_pend) max_pend = issued - accepted;
            if (done) begin done_cnt++; if (done_edge < 0) done_edge = n; end
            prev_stall = px_valid && !px_ready;
            prev_data = px_data; prev_idx = px_index; prev_last = px_last;
            if (rst_idx >= 0 && px_valid && int'(px_index) == rst_idx) begin
                reset_hit = 1;
                break;
            end
            if (restart_idx >= 0 && restarted == 0 && px_valid && int'(px_index) == restart_idx) begin
                start = 1'b1;
                restarted = 1;
            end
            if (done_edge >= 0 && n >= done_edge + 4) break;
            @(posedge CLOCK_50); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; px_ready = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (px_valid !== 1'b0) begin fails++; $display("FAIL reset_px_valid: got %b want 0", px_valid); end
        tests++; if (set_count !== 10'd0) begin fails++; $display("FAIL reset_set_count: got %0d want 0", set_count); end
        tests++; if (out_vec !== rst_vec) begin fails++; $display("FAIL reset_outputs: got %h want %h", out_vec, rst_vec); end
        reset = 1'b0;
        @(posedge CLOCK_50); #1;
    endtask

    task automatic test_empty();
        for (int i = 0; i < 784; i++) grid[i] = 1'b0;
        compute_expect();
        run_scan(0, -1, -1);
        tests++; if (first_busy !== 1'b1) begin fails++; $display("FAIL empty_busy_c1: got %b want 1", first_busy); end
        tests++; if (first_rd !== 1'b1 || first_addr !== 10'd0) begin fails++; $display("FAIL empty_first_rd: got rd=%b addr=%0d want rd=1 addr=0", first_rd, first_addr); end
        tests++; if (first_valid !== 2) begin fails++; $display("FAIL empty_first_valid: got edge %0d want 2", first_valid); end
        tests++; if (beats !== 784 || beat_err !== 0) begin fails++; $display("FAIL empty_beats: got %0d beats %0d errors want 784 and 0", beats, beat_err); end
        tests++; if (ones_cnt !== 0) begin fails++; $display("FAIL empty_data: got %0d set beats want 0", ones_cnt); end
        tests++; if (last_cnt !== 1) begin fails++; $display("FAIL empty_last: got %0d last beats want 1", last_cnt); end
        tests++; if (done_edge !== 786) begin fails++; $display("FAIL empty_done_time: got c+%0d want c+787", done_edge + 1); end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL empty_done_count: got %0d want 1", done_cnt); end
        tests++; if (set_count !== 10'd0 || bbox_valid !== 1'b0) begin fails++; $display("FAIL empty_stats: got cnt=%0d bv=%b want 0 0", set_count, bbox_valid); end
    endtask

    task automatic test_single();
        for (int i = 0; i < 784; i++) grid[i] = 1'b0;
        grid[5 * 28 + 3] = 1'b1;
        compute_expect();
        run_scan(0, -1, -1);
        tests++; if (beats !== 784 || beat_err !== 0) begin fails++; $display("FAIL single_beats: got %0d beats %0d errors want 784 and 0", beats, beat_err); end
        tests++; if (ones_cnt !== 1 || one_idx !== 143) begin fails++; $display("FAIL single_pixel: got %0d set at %0d want 1 at 143", ones_cnt, one_idx); end
        tests++; if (set_count !== 10'd1) begin fails++; $display("FAIL single_set_count: got %0d want 1", set_count); end
        tests++; if ({bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y, bbox_valid} !== {5'(exp_minx), 5'(exp_maxx), 5'(exp_miny), 5'(exp_maxy), 1'(exp_bv)}) begin
            fails++; $display("FAIL single_bbox: got x=%0d..%0d y=%0d..%0d v=%b want x=%0d..%0d y=%0d..%0d v=%0d",
                bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y, bbox_valid, exp_minx, exp_maxx, exp_miny, exp_maxy, exp_bv); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 784; i++) grid[i] = 1'b1;
        compute_expect();
        run_scan(0, -1, -1);
        tests++; if (beats !== 784 || beat_err !== 0) begin fails++; $display("FAIL full_beats: got %0d beats %0d errors want 784 and 0", beats, beat_err); end
        tests++; if (ones_cnt !== 784) begin fails++; $display("FAIL full_data: got %0d set beats want 784", ones_cnt); end
        tests++; if (set_count !== 10'd784) begin fails++; $display("FAIL full_set_count: got %0d want 784", set_count); end
        tests++; if ({bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y, bbox_valid} !== {5'(exp_minx), 5'(exp_maxx), 5'(exp_miny), 5'(exp_maxy), 1'(exp_bv)}) begin
            fails++; $display("FAIL full_bbox: got x=%0d..%0d y=%0d..%0d v=%b want x=%0d..%0d y=%0d..%0d v=%0d",
                bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y, bbox_valid, exp_minx, exp_maxx, exp_miny, exp_maxy, exp_bv); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 784; i++) grid[i] = (i % 7 == 0);
        compute_expect();
        run_scan(1, -1, -1);
        tests++; if (stall_err !== 0) begin fails++; $display("FAIL stall_stable: got %0d unstable cycles want 0", stall_err); end
        tests++; if (beats !== 784 || beat_err !== 0 || exp_idx !== 784) begin fails++; $display("FAIL stall_order: got %0d beats %0d errors want 784 and 0", beats, beat_err); end
        tests++; if (max_pend > 2) begin fails++; $display("FAIL stall_pending: got %0d pending want at most 2", max_pend); end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL stall_done: got %0d done pulses want 1", done_cnt); end
        tests++; if (set_count !== 10'(exp_cnt)) begin fails++; $display("FAIL stall_set_count: got %0d want %0d", set_count, exp_cnt); end
        tests++; if ({bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y, bbox_valid} !== {5'(exp_minx), 5'(exp_maxx), 5'(exp_miny), 5'(exp_maxy), 1'(exp_bv)}) begin
            fails++; $display("FAIL stall_bbox: got x=%0d..%0d y=%0d..%0d v=%b want x=%0d..%0d y=%0d..%0d v=%0d",
                bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y, bbox_valid, exp_minx, exp_maxx, exp_miny, exp_maxy, exp_bv); end
    endtask

    task automatic test_reset_mid_scan();
        for (int i = 0; i < 784; i++) grid[i] = (i % 5 == 1);
        compute_expect();
        run_scan(0, 400, -1);
        tests++; if (reset_hit !== 1) begin fails++; $display("FAIL midrst_reach: got %0d want 1 (index 400 not seen)", reset_hit); end
        reset = 1'b1;
        @(posedge CLOCK_50); #1;
        tests++; if (out_vec !== rst_vec) begin fails++; $display("FAIL midrst_outputs: got %h want %h", out_vec, rst_vec); end
        reset = 1'b0;
        run_scan(0, -1, -1);
        tests++; if (beats !== 784 || beat_err !== 0) begin fails++; $display("FAIL midrst_rescan: got %0d beats %0d errors want 784 and 0", beats, beat_err); end
        tests++; if (done_edge !== 786) begin fails++; $display("FAIL midrst_done_time: got c+%0d want c+787", done_edge + 1); end
        tests++; if (set_count !== 10'(exp_cnt)) begin fails++; $display("FAIL midrst_set_count: got %0d want %0d", set_count, exp_cnt); end
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < 784; i++) grid[i] = (i % 3 == 0);
        compute_expect();
        run_scan(0, -1, 100);
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL restart_done_count: got %0d want 1", done_cnt); end
        tests++; if (done_edge !== 786) begin fails++; $display("FAIL restart_done_time: got c+%0d want c+787", done_edge + 1); end
        tests++; if (beats !== 784 || beat_err !== 0) begin fails++; $display("FAIL restart_beats: got %0d beats %0d errors want 784 and 0", beats, beat_err); end
        tests++; if (set_count !== 10'(exp_cnt)) begin fails++; $display("FAIL restart_set_count: got %0d want %0d", set_count, exp_cnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL restart_idle: got busy=%b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single();
        test_full();
        test_backpressure();
        test_reset_mid_scan();
        test_start_ignored();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
